// File: rtl/instr_encoder_loader.sv
// Encodes field-level RV32I descriptors into 32-bit words and writes them sequentially into instruction memory.
// Optional macro ENC_RANGE_CHECK_EN: flag immediates that do not fit their encoding (word is still written truncated).
module instr_encoder_loader #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [20:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic [31:0] word;
  logic        reserved;
  logic        range_bad;
  logic        accept;

  // Handshake: a descriptor transfers on a cycle where in_valid && in_ready; in_ready never waits on in_valid,
  // and is low in a start cycle so a descriptor presented together with start is not taken.
  assign in_ready = (state_q == ST_LOAD) && !start && (count_q < CAPACITY);
  assign accept   = in_valid && in_ready;

  always_comb begin
    word     = NOP_WORD;
    reserved = 1'b0;
    case (in_class)
      3'd0: word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
      3'd1: word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
      3'd2: word = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_RTYPE};
      3'd3: word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11],
                    OP_BRANCH};
      3'd4: begin
        // Shifts carry funct7b5 in the upper bits and a 5-bit shamt.
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
          word = {1'b0, in_funct7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_IALU};
        else
          word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IALU};
      end
      3'd5: word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
      3'd6: word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
      default: begin
        word     = NOP_WORD;
        reserved = 1'b1;
      end
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic imm12_ok;
  logic imm13_ok;
  assign imm12_ok = (in_imm[20:11] == {10{in_imm[11]}});
  assign imm13_ok = (in_imm[20:12] == {9{in_imm[12]}});

  always_comb begin
    range_bad = 1'b0;
    case (in_class)
      3'd0, 3'd1, 3'd4, 3'd6: range_bad = !imm12_ok;
      3'd3:                   range_bad = !imm13_ok || in_imm[0];
      3'd5:                   range_bad = in_imm[0];
      default:                range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (start) begin
      state_d = ST_LOAD;
      ptr_d   = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else if (accept) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = ptr_q;
      mem_wdata_d = word;
      ptr_d       = ptr_q + PTR_ONE;
      count_d     = count_q + CNT_ONE;
      if (reserved || range_bad)
        err_d = 1'b1;
      if (in_last) begin
        state_d = ST_DONE;
      end else if (count_q == CAPACITY - CNT_ONE) begin
        // Memory filled before the session's last descriptor arrived.
        state_d = ST_DONE;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q == ST_LOAD);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed and randomized bench for instr_encoder_loader against a field-arithmetic reference model.
module tb_instr_encoder_loader;

  localparam int AW  = 3;
  localparam int CAP = 1 << AW;

  logic          clk;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_class;
  logic [2:0]    in_funct3;
  logic          in_funct7b5;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [20:0]   in_imm;
  logic          in_last;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   count;

  int checks   = 0;
  int failures = 0;

  // Session model: phase 0 idle, 1 loading, 2 done.
  int m_phase = 0;
  int m_count = 0;
  bit m_err   = 0;
  logic [31:0] exp_q[$];

  instr_encoder_loader #(.ADDR_W(AW), .NOP_WORD(32'h0000_0013)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] u, input int lo, input int n);
    return (u >> lo) & ((32'd1 << n) - 32'd1);
  endfunction

  function automatic logic [31:0] ref_word(input int cls, input int f3, input int f7, input int rd,
                                           input int rs1, input int rs2, input logic [20:0] imm);
    logic [31:0] u;
    logic [31:0] regs;
    u    = {11'b0, imm};
    regs = (32'(rs1) << 15) + (32'(f3) << 12);
    case (cls)
      0: return (fld(u, 0, 12) << 20) + regs + (32'(rd) << 7) + 32'd3;
      1: return (fld(u, 5, 7) << 25) + (32'(rs2) << 20) + regs + (fld(u, 0, 5) << 7) + 32'd35;
      2: return (32'(f7) << 30) + (32'(rs2) << 20) + regs + (32'(rd) << 7) + 32'd51;
      3: return (fld(u, 12, 1) << 31) + (fld(u, 5, 6) << 25) + (32'(rs2) << 20) + regs
                + (fld(u, 1, 4) << 8) + (fld(u, 11, 1) << 7) + 32'd99;
      4: begin
        if (f3 == 1 || f3 == 5)
          return (32'(f7) << 30) + (fld(u, 0, 5) << 20) + regs + (32'(rd) << 7) + 32'd19;
        return (fld(u, 0, 12) << 20) + regs + (32'(rd) << 7) + 32'd19;
      end
      5: return (fld(u, 20, 1) << 31) + (fld(u, 1, 10) << 21) + (fld(u, 11, 1) << 20)
                + (fld(u, 12, 8) << 12) + (32'(rd) << 7) + 32'd111;
      6: return (fld(u, 0, 12) << 20) + (32'(rs1) << 15) + (32'(rd) << 7) + 32'd103;
      default: return 32'h0000_0013;
    endcase
  endfunction

  function automatic bit ref_flags_err(input int cls, input logic [20:0] imm);
    int sv;
    sv = imm[20] ? int'({11'b0, imm}) - (1 << 21) : int'({11'b0, imm});
    if (cls == 7) return 1'b1;
`ifdef ENC_RANGE_CHECK_EN
    case (cls)
      0, 1, 4, 6: return (sv < -2048) || (sv > 2047);
      3:          return (sv < -4096) || (sv > 4095) || (sv % 2 != 0);
      5:          return (sv % 2 != 0);
      default:    return 1'b0;
    endcase
`else
    return (sv != sv);
`endif
  endfunction

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(count), 32'(m_count));
    check({tag, "_err"},   32'(err),   32'(m_err));
    check({tag, "_busy"},  32'(busy),  32'(m_phase == 1));
    check({tag, "_done"},  32'(done),  32'(m_phase == 2));
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_we", 32'(mem_we), 32'd0);
    check_status("idle");
  endtask

  task automatic do_start(input bit with_valid);
    start    = 1'b1;
    in_valid = with_valid;
    in_class = 3'd0;
    in_last  = 1'b1;
    #2;
    check("start_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    m_phase  = 1;
    m_count  = 0;
    m_err    = 1'b0;
    check("start_we", 32'(mem_we), 32'd0);
    check_status("start");
  endtask

  task automatic send(input int cls, input int f3, input int f7, input int rd, input int rs1,
                      input int rs2, input logic [20:0] imm, input bit last);
    bit exp_rdy;
    int addr;
    in_class = 3'(cls); in_funct3 = 3'(f3); in_funct7b5 = f7[0];
    in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm; in_last = last;
    in_valid = 1'b1;
    #2;
    exp_rdy = (m_phase == 1) && (m_count < CAP);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (exp_rdy) begin
      exp_q.push_back(ref_word(cls, f3, f7, rd, rs1, rs2, imm));
      addr = m_count;
      m_count++;
      if (ref_flags_err(cls, imm)) m_err = 1'b1;
      if (last) m_phase = 2;
      else if (m_count == CAP) begin
        m_phase = 2;
        m_err   = 1'b1;
      end
      check("wr_we",    32'(mem_we),   32'd1);
      check("wr_addr",  32'(mem_addr), 32'(addr));
      check("wr_wdata", mem_wdata,     exp_q.pop_front());
    end else begin
      check("nowr_we", 32'(mem_we), 32'd0);
    end
    check_status("send");
  endtask

  task automatic rand_send(input bit last);
    int cls;
    int mode;
    logic [20:0] imm;
    cls  = ($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, 6));
    mode = $urandom_range(0, 3);
    if (mode < 2)       imm = 21'(int'($urandom_range(0, 4095)) - 2048);
    else if (mode == 2) imm = 21'((int'($urandom_range(0, 4095)) - 2048) * 2);
    else                imm = 21'($urandom);
    send(cls, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 31),
         $urandom_range(0, 31), $urandom_range(0, 31), imm, last);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_class = 3'd0; in_funct3 = 3'd0;
    in_funct7b5 = 1'b0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 21'd0; in_last = 1'b0;
    #1;
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check_status("rst");
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    check_status("post_rst");

    // Idle: descriptors are not taken before a session starts.
    send(0, 2, 0, 5, 2, 0, 21'd8, 1'b1);

    do_start(1'b0);
    send(0, 2, 0, 5, 2, 0, 21'd8, 1'b1);
    check("t1_word", mem_wdata, 32'h0081_2283);
    idle_cycle();
    check("hold_wdata", mem_wdata, 32'h0081_2283);

    do_start(1'b1);
    send(2, 0, 0, 3, 1, 2, 21'd0, 1'b0);
    check("r_add", mem_wdata, 32'h0020_81B3);
    send(2, 0, 1, 3, 1, 2, 21'd0, 1'b1);
    check("r_sub", mem_wdata, 32'h4020_81B3);

    do_start(1'b0);
    send(3, 0, 0, 0, 1, 2, 21'h1F_FFF8, 1'b0);
    check("beq_m8", mem_wdata, 32'hFE20_8CE3);
    send(5, 0, 0, 1, 0, 0, 21'd16, 1'b1);
    check("jal_16", mem_wdata, 32'h0100_00EF);

    // Capacity reached without last, then one more that must be refused.
    do_start(1'b0);
    for (int i = 0; i <= CAP; i++) send(i % 7, 0, 0, i, i + 1, i + 2, 21'(4 * i), 1'b0);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_count", 32'(count), 32'(CAP));

    // Capacity reached exactly on the last descriptor.
    do_start(1'b0);
    for (int i = 0; i < CAP; i++) send(2, i % 8, i % 2, i, 1, 2, 21'd0, i == CAP - 1);

    do_start(1'b0);
    send(7, 0, 0, 1, 1, 1, 21'd0, 1'b1);
    check("nop_word", mem_wdata, 32'h0000_0013);
    do_start(1'b0);
    send(0, 2, 0, 1, 0, 0, 21'd4, 1'b1);
    check("after_err_addr", 32'(mem_addr), 32'd0);

    // Restart in the middle of a session.
    do_start(1'b0);
    send(4, 0, 0, 1, 2, 0, 21'd5, 1'b0);
    send(4, 5, 1, 1, 2, 0, 21'd3, 1'b0);
    do_start(1'b0);
    send(6, 3, 0, 1, 2, 0, 21'h1F_FFFC, 1'b1);

    // Out-of-range immediate.
    do_start(1'b0);
    send(0, 2, 0, 5, 2, 0, 21'd2048, 1'b1);

    for (int s = 0; s < 25; s++) begin
      int len;
      do_start($urandom_range(0, 1));
      len = $urandom_range(1, CAP + 2);
      for (int i = 0; i < len; i++) begin
        rand_send(i == len - 1);
        if ($urandom_range(0, 3) == 0) idle_cycle();
      end
    end

    // Asynchronous reset right after an accept kills the pending strobe.
    do_start(1'b0);
    send(1, 2, 0, 0, 3, 4, 21'd12, 1'b0);
    reset = 1'b0;
    #1;
    m_phase = 0; m_count = 0; m_err = 1'b0;
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'd0);
    check("arst_wdata", mem_wdata, 32'd0);
    check("arst_ready", 32'(in_ready), 32'd0);
    check_status("arst");
    #2;
    reset = 1'b1;
    send(0, 2, 0, 5, 2, 0, 21'd8, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
